// File: rtl/spi_slave.sv
// Byte-oriented SPI responder (mode: change on sclk rise, sample on sclk fall, cs active low, MSB first).
// Pins are oversampled in the i_clk domain; one-entry transmit buffer with bypass on load.
module spi_slave #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sclk,
    input  logic             i_cs,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_tx_underrun,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // state  | meaning
    // IDLE   | synchronized cs high, sclk ignored
    // ACTIVE | synchronized cs low, shifting bytes
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    logic w_load;
    logic w_tx_bit;
    logic w_rx_bit;
    logic w_rx_done;
    logic w_abort;
    logic w_buf_wr;

    logic [WIDTH-1:0] r_tx_shift;
    logic [WIDTH-1:0] r_tx_buf;
    logic             r_buf_full;
    logic [WIDTH-1:0] r_rx_shift;
    logic [WIDTH-1:0] w_rx_word;
    logic [CW-1:0]    r_bit_cnt;
    logic             r_miso;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;
    logic             r_tx_underrun;
    logic             r_frame_err;

    // Synchronizers reset to the idle pin levels so reset itself never looks like an edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // cs_rise takes priority over any coincident sclk edge; the pending bit is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tx_bit    = 1'b0;
        w_rx_bit    = 1'b0;
        w_rx_done   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_tx_bit = w_sclk_rise;
                    if (w_sclk_fall) begin
                        w_rx_bit = 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_rx_done = 1'b1;
                            w_load    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A write landing on a load cycle with the buffer empty bypasses straight into the shifter.
    assign w_buf_wr = i_tx_valid & ~r_buf_full & ~w_load;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_shift    <= '0;
            r_tx_buf      <= '0;
            r_buf_full    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_tx_underrun <= 1'b0;
            if (w_load) begin
                if (r_buf_full) begin
                    r_tx_shift <= r_tx_buf;
                    r_buf_full <= 1'b0;
                end else if (i_tx_valid) begin
                    r_tx_shift <= i_tx_data;
                end else begin
                    r_tx_shift    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_tx_bit) begin
                r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end
            if (w_buf_wr) begin
                r_tx_buf   <= i_tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_miso <= 1'b0;
        end else if (w_abort) begin
            r_miso <= 1'b0;
        end else if (w_tx_bit) begin
            r_miso <= r_tx_shift[WIDTH-1];
        end
    end

    assign w_rx_word = {r_rx_shift[WIDTH-2:0], w_mosi_s};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rx_shift  <= '0;
            r_bit_cnt   <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_abort) begin
                r_bit_cnt   <= '0;
                r_frame_err <= (r_bit_cnt != '0);
            end else if (w_rx_bit) begin
                r_rx_shift <= w_rx_word;
                if (w_rx_done) begin
                    r_bit_cnt  <= '0;
                    r_rx_data  <= w_rx_word;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end
        end
    end

    assign o_miso        = r_miso;
    assign o_miso_oe     = (r_state == ST_ACTIVE);
    assign o_busy        = (r_state == ST_ACTIVE);
    assign o_tx_ready    = ~r_buf_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master with hand-computed expected bytes.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       frame_err;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int rx_cnt = 0;
    int und_cnt = 0;
    int ferr_cnt = 0;

    always #5 clk = ~clk;

    spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_sclk       (sclk),
        .i_cs         (cs),
        .i_mosi       (mosi),
        .o_miso       (miso),
        .o_miso_oe    (miso_oe),
        .i_tx_data    (tx_data),
        .i_tx_valid   (tx_valid),
        .o_tx_ready   (tx_ready),
        .o_rx_data    (rx_data),
        .o_rx_valid   (rx_valid),
        .o_tx_underrun(tx_underrun),
        .o_frame_err  (frame_err),
        .o_busy       (busy)
    );

    always @(negedge clk) begin
        if (rx_valid)    rx_cnt++;
        if (tx_underrun) und_cnt++;
        if (frame_err)   ferr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic queue_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        cs = 1'b0;
        cs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Master drives mosi on sclk rise and samples miso on sclk fall, half-period 8 clk.
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            mosi = b[7-i];
            repeat (8) @(negedge clk);
            sclk = 1'b0;
            got  = {got[6:0], miso};
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_miso"}, {31'd0, miso}, 32'd0);
        chk({pfx, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
        chk({pfx, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        chk({pfx, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({pfx, "_underrun"}, {31'd0, tx_underrun}, 32'd0);
        chk({pfx, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        chk({pfx, "_busy"}, {31'd0, busy}, 32'd0);
        chk({pfx, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
        chk({pfx, "_bit_cnt"}, {29'd0, dut.r_bit_cnt}, 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        int rx0, und0, ferr0;

        reset = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // single byte
        queue_byte(8'hA5);
        chk("t1_ready_after_q", {31'd0, tx_ready}, 32'd0);
        rx0 = rx_cnt;
        frame_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_miso_oe", {31'd0, miso_oe}, 32'd1);
        chk("t1_ready_after_load", {31'd0, tx_ready}, 32'd1);
        send_bits(8'h3C, 8, got);
        chk("t1_miso_byte", {24'd0, got}, 32'hA5);
        chk("t1_rx_data", {24'd0, rx_data}, 32'h3C);
        chk("t1_rx_pulses", rx_cnt - rx0, 32'd1);
        frame_end();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // back-to-back bytes, second written while busy
        queue_byte(8'h12);
        rx0 = rx_cnt;
        frame_start();
        queue_byte(8'h34);
        chk("t2_ready_full", {31'd0, tx_ready}, 32'd0);
        send_bits(8'hF0, 8, got);
        chk("t2_miso_b0", {24'd0, got}, 32'h12);
        chk("t2_rx_b0", {24'd0, rx_data}, 32'hF0);
        send_bits(8'h0F, 8, got);
        chk("t2_miso_b1", {24'd0, got}, 32'h34);
        chk("t2_rx_b1", {24'd0, rx_data}, 32'h0F);
        chk("t2_rx_pulses", rx_cnt - rx0, 32'd2);
        frame_end();

        // underrun
        und0 = und_cnt;
        rx0  = rx_cnt;
        frame_start();
        chk("t3_underrun_at_start", und_cnt - und0, 32'd1);
        send_bits(8'h81, 8, got);
        chk("t3_miso_zero", {24'd0, got}, 32'h00);
        chk("t3_rx_data", {24'd0, rx_data}, 32'h81);
        chk("t3_rx_pulses", rx_cnt - rx0, 32'd1);
        frame_end();

        // abort after 5 bits, then a clean frame
        rx0   = rx_cnt;
        ferr0 = ferr_cnt;
        frame_start();
        send_bits(8'hFF, 5, got);
        frame_end();
        chk("t4_no_rx", rx_cnt - rx0, 32'd0);
        chk("t4_frame_err", ferr_cnt - ferr0, 32'd1);
        chk("t4_bit_cnt", {29'd0, dut.r_bit_cnt}, 32'd0);
        chk("t4_miso_low", {31'd0, miso}, 32'd0);
        rx0   = rx_cnt;
        ferr0 = ferr_cnt;
        frame_start();
        send_bits(8'h55, 8, got);
        frame_end();
        chk("t4_rx_after", {24'd0, rx_data}, 32'h55);
        chk("t4_rx_pulses_after", rx_cnt - rx0, 32'd1);
        chk("t4_no_ferr_after", ferr_cnt - ferr0, 32'd0);

        // bypass: tx_valid only on the cs_fall load cycle
        und0 = und_cnt;
        @(negedge clk);
        cs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t5_ready_stays", {31'd0, tx_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        chk("t5_no_underrun", und_cnt - und0, 32'd0);
        send_bits(8'h00, 8, got);
        chk("t5_miso_byte", {24'd0, got}, 32'hC3);
        frame_end();

        // reset mid-byte with a byte still buffered
        queue_byte(8'h99);
        frame_start();
        queue_byte(8'hAA);
        send_bits(8'hE0, 3, got);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t6");
        cs = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        queue_byte(8'h7E);
        rx0 = rx_cnt;
        frame_start();
        send_bits(8'h18, 8, got);
        chk("t6_miso_byte", {24'd0, got}, 32'h7E);
        chk("t6_rx_data", {24'd0, rx_data}, 32'h18);
        chk("t6_rx_pulses", rx_cnt - rx0, 32'd1);
        frame_end();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI responder, the far-end counterpart of the team's SPI master. Oversamples the external `sclk`, `cs` and `mosi` pins in the system clock domain, delivers each received byte on a one-cycle strobe, and shifts out a byte queued through a valid/ready transmit port. Bus protocol: `cs` active low, MSB first. Both ends change data on `sclk` rising edges and sample on `sclk` falling edges.

## Interface
- `WIDTH`, 8: bits per transfer.
- `SYNC_STAGES`, 2: flip-flop stages on each pin input (≥2).
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `sclk`  input  1  SPI serial clock from master (asynchronous to `clk`).
- `cs`  input  1  chip select from master, active low (asynchronous).
- `mosi`  input  1  master-out data (asynchronous).
- `miso`  output  1  slave-out data, registered.
- `miso_oe`  output  1  high while synchronized `cs` is low; board-level tristate enable.
- `tx_data`  input  WIDTH  byte to transmit.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  holding buffer empty; a write is accepted on `tx_valid && tx_ready`.
- `rx_data`  output  WIDTH  last complete received byte; held until the next one.
- `rx_valid`  output  1  one-cycle strobe; `rx_data` is updated in the same cycle.
- `tx_underrun`  output  1  one-cycle pulse: a byte started with no data queued, so zeros are sent.
- `frame_err`  output  1  one-cycle pulse: `cs` deasserted with a partial byte (1..WIDTH-1 bits).
- `busy`  output  1  synchronized `cs` low.

## Operation
- Pin inputs pass through `SYNC_STAGES` flops, then one history flop for edge detection. The block derives `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` from the synchronized signals.
- States:
  - IDLE: synchronized `cs` high.
  - ACTIVE: synchronized `cs` low.
  - IDLE→ACTIVE on `cs_fall`. ACTIVE→IDLE on `cs_rise`.
  - `sclk` edges are ignored in IDLE.
- Byte load happens on `cs_fall` and again after every completed byte while ACTIVE:
  - If the buffer is full: `tx_shift <= buffer`, and the buffer empties.
  - Else if `tx_valid` is high the same cycle: `tx_shift <= tx_data` (bypass). The buffer stays empty and the write counts as accepted.
  - Else: `tx_shift <= 0` and `tx_underrun` pulses.
- `sclk_rise` in ACTIVE: `miso <= tx_shift[WIDTH-1]`, then `tx_shift` shifts left with 0 fill.
- `sclk_fall` in ACTIVE:
  - `rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}` and `bit_cnt` increments.
  - When `bit_cnt == WIDTH-1`: `rx_data <=` the completed word, `rx_valid` pulses, `bit_cnt <= 0`, and the byte load fires.
- Back-to-back bytes under one `cs` assertion are supported without gaps.
- There is no receive back-pressure. The consumer must take `rx_data` before the next strobe.
- `cs_rise`:
  - `bit_cnt <= 0` and `miso <= 0`.
  - If `bit_cnt != 0`: the partial byte is discarded (no `rx_valid`) and `frame_err` pulses.
  - A byte already moved into `tx_shift` is lost; the buffer content is kept.
- Transmit buffer: one entry. `tx_ready = !buffer_full`. A write while ACTIVE is allowed and is used at the next byte load.
- `sclk_rise` and `sclk_fall` cannot coincide. If `cs_rise` coincides with `sclk_fall`, `cs_rise` wins and the bit is discarded.
- `reset` mid-transfer returns to IDLE immediately. Buffer, shift registers and counter clear; the master's byte is lost.
- Reset values:
  - 0: `miso`, `miso_oe`, `rx_data`, `rx_valid`, `tx_underrun`, `frame_err`, `busy`, `bit_cnt`.
  - 1: `tx_ready`.
  - Synchronizers reset to the idle pin levels: `cs` = 1, `sclk` = 0, `mosi` = 0.

## Timing
- Pin-to-edge latency is `SYNC_STAGES` + 1 `clk` cycles (3 by default).
- `miso` changes 3 cycles after the `sclk` pin rises. `rx_valid` asserts 3 cycles after the last `sclk` pin falling edge.
- Constraints on the master:
  - `sclk` high and low phases each ≥ 4 `clk` periods.
  - `cs` low ≥ 4 `clk` periods before the first `sclk` rise.
  - `cs` high ≥ 4 `clk` periods between frames.
  - `mosi` stable from 1 cycle before to 3 cycles after the `sclk` falling pin edge.
- `tx_ready` rises the cycle after a load empties the buffer. `tx_data` written at least 1 cycle before `cs_fall` is sent in that frame.

## Test plan
- Single byte: queue 0xA5, master sends 0x3C with sclk half-period 8 clk -> master receives 0xA5; `rx_data` = 0x3C with one `rx_valid` pulse; `tx_ready` returns to 1.
- Back-to-back: queue 0x12, then write 0x34 while busy; master clocks 16 bits (0xF0, 0x0F) -> miso sequence 0x12, 0x34; two `rx_valid` pulses with 0xF0 then 0x0F.
- Underrun: no tx data, frame of one byte 0x81 -> miso all zeros, `tx_underrun` pulses once at `cs_fall`, `rx_data` = 0x81.
- Abort: `cs` raised after 5 bits -> no `rx_valid`, `frame_err` pulses once, `bit_cnt` = 0; next full frame 0x55 is received correctly.
- Bypass: `tx_valid` with 0xC3 asserted exactly on the `cs_fall` load cycle with the buffer empty -> master receives 0xC3, no underrun, `tx_ready` stays 1.
- Reset mid-byte after 3 bits -> all outputs at reset values; the following frame with 0x7E queued works normally.
